// File: rtl/spike_fifo_pkg.sv
// Shared widths and types for the spike-event FIFO in the AER path.
// Default geometry is 256 x 8-bit spike addresses.
package spike_fifo_pkg;
  localparam int DEPTH_DEF = 256;
  localparam int M_DEF     = 8;
  localparam int PTR_W     = $clog2(DEPTH_DEF);
  localparam int CNT_W     = PTR_W + 1;

  typedef logic [M_DEF-1:0] spike_addr_t;

  // Occupancy width for an arbitrary depth: one extra bit so DEPTH itself fits.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/spike_fifo_mem.sv
// 1W1R spike storage, DEPTH x M, no reset on the array.
// FWFT=1 exposes the asynchronous read port; FWFT=0 registers the read word on re.
module spike_fifo_mem #(
  parameter int DEPTH = 256,
  parameter int M     = 8,
  parameter bit FWFT  = 1'b0
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [M-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [M-1:0]             rdata
);
  logic [M-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (FWFT) begin : g_fwft
      assign rdata = mem[raddr];
    end else begin : g_reg
      // Same-cycle write to raddr (full pop+push) returns the old word.
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end
  endgenerate
endmodule

// File: rtl/spike_fifo_ctrl.sv
// Spike-event FIFO controller: pointers, occupancy flags, flush and error accounting.
// Storage lives in spike_fifo_mem; status outputs derive only from registered state.
module spike_fifo_ctrl
  import spike_fifo_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int M         = M_DEF,
  parameter bit FWFT      = 1'b0,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  parameter int DROP_W    = 16
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     flush_i,
  input  logic                     w_en_i,
  input  logic [M-1:0]             w_data_i,
  input  logic                     r_en_i,
  output logic [M-1:0]             r_data_o,
  output logic                     r_valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o,
  output logic [DROP_W-1:0]        drop_cnt_o,
  input  logic                     clr_err_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_TH);

  logic [CW-1:0] w_ptr, r_ptr, count;
  logic          empty, full, rd, wr, ovf_ev, udf_ev;

  assign count = w_ptr - r_ptr;
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // Flush wins over every accept and is not itself an error event.
  assign rd     = r_en_i & ~empty & ~flush_i;
  assign wr     = w_en_i & (~full | rd) & ~flush_i;
  assign ovf_ev = w_en_i & full & ~rd & ~flush_i;
  assign udf_ev = r_en_i & empty & ~flush_i;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else if (flush_i) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (wr) w_ptr <= w_ptr + 1'b1;
      if (rd) r_ptr <= r_ptr + 1'b1;
    end
  end

  // Error clear loses to a coincident event: flag stays set, drop count restarts at 1.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      drop_cnt_o  <= '0;
    end else if (clr_err_i) begin
      overflow_o  <= ovf_ev;
      underflow_o <= udf_ev;
      drop_cnt_o  <= ovf_ev ? DROP_W'(1) : '0;
    end else begin
      if (ovf_ev) overflow_o  <= 1'b1;
      if (udf_ev) underflow_o <= 1'b1;
      if (ovf_ev && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

  assign count_o        = count;
  assign empty_o        = empty;
  assign full_o         = full;
  assign almost_full_o  = (count >= AF_CNT);
  assign almost_empty_o = (count <= AE_CNT);

  generate
    if (FWFT) begin : g_fwft_vld
      assign r_valid_o = ~empty;
    end else begin : g_reg_vld
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) r_valid_o <= 1'b0;
        else       r_valid_o <= rd;
      end
    end
  endgenerate

  spike_fifo_mem #(
    .DEPTH (DEPTH),
    .M     (M),
    .FWFT  (FWFT)
  ) u_mem (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .we    (wr),
    .waddr (w_ptr[AW-1:0]),
    .wdata (w_data_i),
    .re    (rd),
    .raddr (r_ptr[AW-1:0]),
    .rdata (r_data_o)
  );
endmodule

// File: tb/tb_spike_fifo_ctrl.sv
// Bench for spike_fifo_ctrl: registered-read and FWFT instances share stimulus and
// are checked each cycle against a queue model, plus directed literal checks.
module tb_spike_fifo_ctrl;
  import spike_fifo_pkg::*;

  localparam int D    = 8;
  localparam int AF   = 4;
  localparam int AE   = 2;
  localparam int DMAX = 7;

  logic        CLK = 1'b0, RSTN = 1'b0;
  logic        flush = 1'b0, w_en = 1'b0, r_en = 1'b0, clr = 1'b0;
  spike_addr_t wd = '0;

  logic [7:0] rd0, rd1;
  logic       rv0, rv1, full0, full1, emp0, emp1, af0, af1, ae0, ae1;
  logic       ovf0, ovf1, udf0, udf1;
  logic [3:0] cnt0, cnt1;
  logic [2:0] drp0, drp1;

  spike_fifo_ctrl #(.DEPTH(D), .M(8), .FWFT(1'b0), .AFULL_TH(AF), .AEMPTY_TH(AE), .DROP_W(3)) u0 (
    .CLK(CLK), .RSTN(RSTN), .flush_i(flush), .w_en_i(w_en), .w_data_i(wd), .r_en_i(r_en),
    .r_data_o(rd0), .r_valid_o(rv0), .full_o(full0), .empty_o(emp0), .almost_full_o(af0),
    .almost_empty_o(ae0), .count_o(cnt0), .overflow_o(ovf0), .underflow_o(udf0),
    .drop_cnt_o(drp0), .clr_err_i(clr));

  spike_fifo_ctrl #(.DEPTH(D), .M(8), .FWFT(1'b1), .AFULL_TH(AF), .AEMPTY_TH(AE), .DROP_W(3)) u1 (
    .CLK(CLK), .RSTN(RSTN), .flush_i(flush), .w_en_i(w_en), .w_data_i(wd), .r_en_i(r_en),
    .r_data_o(rd1), .r_valid_o(rv1), .full_o(full1), .empty_o(emp1), .almost_full_o(af1),
    .almost_empty_o(ae1), .count_o(cnt1), .overflow_o(ovf1), .underflow_o(udf1),
    .drop_cnt_o(drp1), .clr_err_i(clr));

  always #5 CLK = ~CLK;

  int n_tests = 0, n_fail = 0;
  bit chk_on = 0;

  // Reference model: a queue of stored words plus error state.
  logic [7:0] q[$];
  bit         m_ovf, m_udf, m_rv;
  int         m_drop;
  logic [7:0] m_rdat;
  int         cn;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_rv = 0; m_drop = 0; m_rdat = '0;
  endtask

  task automatic model_step();
    bit rd, wr, ev_o, ev_u;
    int n;
    n = q.size();
    if (flush) begin
      rd = 0; wr = 0; ev_o = 0; ev_u = 0;
    end else begin
      rd   = r_en && (n > 0);
      wr   = w_en && ((n < D) || rd);
      ev_o = w_en && (n == D) && !rd;
      ev_u = r_en && (n == 0);
    end
    if (clr) begin
      m_ovf = ev_o; m_udf = ev_u; m_drop = ev_o ? 1 : 0;
    end else begin
      if (ev_o) m_ovf = 1;
      if (ev_u) m_udf = 1;
      if (ev_o && m_drop < DMAX) m_drop++;
    end
    m_rv = rd;
    if (rd) m_rdat = q.pop_front();
    if (wr) q.push_back(wd);
    if (flush) q.delete();
  endtask

  task automatic cyc(input bit w, input int d, input bit r, input bit f = 0, input bit c = 0);
    logic [31:0] dv;
    dv = d;
    w_en = w; wd = dv[7:0]; r_en = r; flush = f; clr = c;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    w_en = 0; r_en = 0; flush = 0; clr = 0;
  endtask

  always @(negedge CLK) begin
    if (RSTN && chk_on) begin
      cn = q.size();
      chk("count0", int'(cnt0), cn);        chk("count1", int'(cnt1), cn);
      chk("empty0", int'(emp0), int'(cn == 0)); chk("empty1", int'(emp1), int'(cn == 0));
      chk("full0", int'(full0), int'(cn == D)); chk("full1", int'(full1), int'(cn == D));
      chk("afull0", int'(af0), int'(cn >= AF)); chk("afull1", int'(af1), int'(cn >= AF));
      chk("aempty0", int'(ae0), int'(cn <= AE)); chk("aempty1", int'(ae1), int'(cn <= AE));
      chk("ovf0", int'(ovf0), int'(m_ovf));  chk("ovf1", int'(ovf1), int'(m_ovf));
      chk("udf0", int'(udf0), int'(m_udf));  chk("udf1", int'(udf1), int'(m_udf));
      chk("drop0", int'(drp0), m_drop);      chk("drop1", int'(drp1), m_drop);
      chk("rvalid0", int'(rv0), int'(m_rv));
      chk("rdata0", int'(rd0), int'(m_rdat));
      chk("rvalid1", int'(rv1), int'(cn > 0));
      if (cn > 0) chk("rdata1", int'(rd1), int'(q[0]));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    chk_on = 1;
    @(negedge CLK);
    chk("rst_count", int'(cnt0), 0); chk("rst_empty", int'(emp0), 1);
    chk("rst_aempty", int'(ae0), 1); chk("rst_afull", int'(af0), 0);
    chk("rst_full", int'(full0), 0); chk("rst_rvalid", int'(rv0), 0);
    chk("rst_rdata", int'(rd0), 0);  chk("rst_drop", int'(drp0), 0);

    // Fill 0x01..0x08; almost_full from count 4
    for (int i = 1; i <= 8; i++) begin
      cyc(1, i, 0);
      chk("fill_afull", int'(af0), int'(i >= 4));
    end
    chk("fill_full", int'(full0), 1); chk("fill_count", int'(cnt0), 8);

    // Drops while full, then clear; saturation; clear vs coincident drop
    repeat (3) cyc(1, 'hEE, 0);
    chk("drop3_ovf", int'(ovf0), 1); chk("drop3_cnt", int'(drp0), 3);
    cyc(0, 0, 0, 0, 1);
    chk("clr_ovf", int'(ovf0), 0); chk("clr_cnt", int'(drp0), 0);
    repeat (9) cyc(1, 'hEE, 0);
    chk("drop_sat", int'(drp0), 7);
    cyc(1, 'hEE, 0, 0, 1);
    chk("clr_vs_drop_cnt", int'(drp0), 1); chk("clr_vs_drop_ovf", int'(ovf0), 1);
    cyc(0, 0, 0, 0, 1);
    chk("clr2_cnt", int'(drp0), 0);

    // Full pop+push for 20 cycles, wrapping pointers
    for (int i = 0; i < 20; i++) begin
      cyc(1, 'h20 + i, 1);
      chk("wrap_data", int'(rd0), (i < 8) ? i + 1 : 'h20 + i - 8);
      chk("wrap_count", int'(cnt0), 8);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1);
      chk("drain_data", int'(rd0), 'h20 + 12 + i);
    end
    chk("drain_empty", int'(emp0), 1);

    // Empty with write and read together
    cyc(1, 'hAA, 1);
    chk("er_udf", int'(udf0), 1); chk("er_count", int'(cnt0), 1);
    chk("er_fwft_data", int'(rd1), 'hAA); chk("er_rvalid", int'(rv0), 0);
    cyc(0, 0, 1);
    chk("er_read_vld", int'(rv0), 1); chk("er_read_data", int'(rd0), 'hAA);

    // Read latency
    cyc(1, 'h11, 0);
    chk("fwft_pre_pop", int'(rd1), 'h11); chk("fwft_vld", int'(rv1), 1);
    cyc(0, 0, 1);
    chk("lat_vld", int'(rv0), 1); chk("lat_data", int'(rd0), 'h11);
    cyc(0, 0, 0);
    chk("lat_vld_drop", int'(rv0), 0); chk("lat_hold", int'(rd0), 'h11);

    // Flush with a coincident write
    for (int i = 0; i < 5; i++) cyc(1, 'h30 + i, 0);
    chk("pre_flush_cnt", int'(cnt0), 5);
    cyc(1, 'h99, 0, 1);
    chk("flush_cnt", int'(cnt0), 0); chk("flush_empty", int'(emp0), 1);
    chk("flush_keeps_udf", int'(udf0), 1); chk("flush_no_drop", int'(drp0), 0);
    cyc(1, 'h42, 0);
    cyc(0, 0, 1);
    chk("post_flush_data", int'(rd0), 'h42);

    // Randomized traffic: fill-biased then drain-biased
    for (int i = 0; i < 600; i++) begin
      bit w, r, f, c;
      if (i < 300) begin w = ($urandom % 4) != 0; r = ($urandom % 2) != 0; end
      else         begin w = ($urandom % 4) == 0; r = ($urandom % 4) != 0; end
      f = ($urandom % 40) == 0;
      c = ($urandom % 30) == 0;
      cyc(w, $urandom_range(0, 255), r, f, c);
    end

    // Async reset mid-burst
    for (int i = 0; i < 3; i++) cyc(1, 'h50 + i, 0);
    w_en = 1; wd = 8'h5A;
    @(posedge CLK);
    model_step();
    #2 RSTN = 1'b0;
    model_reset();
    #1;
    chk("arst_count", int'(cnt0), 0); chk("arst_empty", int'(emp0), 1);
    chk("arst_ovf", int'(ovf0), 0);   chk("arst_rvalid", int'(rv0), 0);
    chk("arst_rdata", int'(rd0), 0);  chk("arst_count1", int'(cnt1), 0);
    @(negedge CLK);
    w_en = 0;
    @(negedge CLK);
    RSTN = 1'b1;
    cyc(1, 'h77, 0);
    cyc(0, 0, 1);
    chk("post_arst_data", int'(rd0), 'h77);
    cyc(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
